steer_quad_multi: RTL and testbench
===================================

STEER_QUAD_MULTI -- requirements
Module: steer_quad_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent steering channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 16: width of the step-period divider.
REQ-003 SHALL have parameter ACCEL_STEPS, default 4: quadrature steps taken at one acceleration level before moving to the next level (1..255).
REQ-004 SHALL have parameter MAX_LVL, default 3: highest acceleration level (0..7).
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port clkdiv, input, DIV_W bits: base step period in CLK cycles, shared by all channels.
REQ-008 SHALL have port accel_en, input, 1 bit: 1 enables the acceleration ramp.
REQ-009 SHALL have port right, input, CHANNELS bits: per-channel steer-right request, active high, synchronous to CLK.
REQ-010 SHALL have port left, input, CHANNELS bits: per-channel steer-left request, active high.
REQ-011 SHALL have port steer_a, output, CHANNELS bits: quadrature phase A, registered.
REQ-012 SHALL have port steer_b, output, CHANNELS bits: quadrature phase B, registered.
REQ-013 SHALL have port moving, output, CHANNELS bits: 1 while the channel has a valid direction latched, registered.

Function
REQ-014 Each channel SHALL be fully independent and share only clkdiv and accel_en.
REQ-015 Direction SHALL be decoded as: right only -> R; left only -> L; both or neither -> IDLE.
REQ-016 Each channel SHALL hold a 2-bit phase index p; {steer_a,steer_b} = 00, 01, 11, 10 for p = 0, 1, 2, 3.
REQ-017 An R step SHALL set p to p+1 mod 4, and an L step SHALL set p to p-1 mod 4; only one output bit changes per step.
REQ-018 Each channel SHALL register dir_prev, the direction sampled at the previous edge; moving = (dir_prev != IDLE).
REQ-019 When dir != dir_prev, the channel SHALL set cnt to 0, level to 0 and stepcnt to 0, and SHALL NOT step on that edge.
REQ-020 When dir == dir_prev != IDLE and cnt == period-1, the channel SHALL step p, set cnt to 0 and increment stepcnt; otherwise cnt SHALL increment.
REQ-021 On every edge where dir is IDLE, the channel SHALL hold p and set cnt, level and stepcnt to 0.
REQ-022 period SHALL equal clkdiv >> level, with a result of 0 treated as 1.
  - clkdiv = 0 or 1 gives one step per cycle.
REQ-023 The first step after a direction is first sampled SHALL occur exactly period edges later; later steps SHALL occur every period edges.
REQ-024 Acceleration: with accel_en=1, when stepcnt reaches ACCEL_STEPS and level < MAX_LVL, the channel SHALL increment level and set stepcnt to 0.
  - The new period applies from the next interval.
  - At MAX_LVL, level saturates and stepcnt saturates.
REQ-025 With accel_en=0, level SHALL be held at 0.
REQ-026 If accel_en deasserts mid-ramp, level SHALL return to 0 on the next edge and cnt SHALL be kept.
  - If cnt is already >= the new period-1, the step occurs on the next edge.
REQ-027 A clkdiv change mid-interval SHALL take effect immediately and SHALL follow the same rule as REQ-026.
REQ-028 cnt SHALL be DIV_W bits wide and SHALL never wrap, because the cnt >= period-1 compare forces a step.

Reset
REQ-029 While reset=1, every channel SHALL have p=0, steer_a=0, steer_b=0, moving=0, dir_prev=IDLE, cnt=0, level=0 and stepcnt=0.
REQ-030 Reset asserted mid-operation SHALL clear state immediately without waiting for CLK.
REQ-031 After reset release, a held input SHALL be treated as a new direction (REQ-019).

Verification
REQ-032 Scenario: clkdiv=4, accel_en=0, right[0] held from edge 0 -> {A,B}[0] becomes 01 at edge 4, 11 at edge 8, 10 at edge 12 and 00 at edge 16; channel 1 stays 00; moving[0]=1 from edge 0.
REQ-033 Scenario: clkdiv=8, ACCEL_STEPS=2, MAX_LVL=3, accel_en=1, left[0] held -> step intervals are 8,8,4,4,2,2,1,1,1...; the phase sequence is 00,10,11,01,00.
REQ-034 Scenario: right held for 6 edges with clkdiv=4, then left -> no step on the reversal edge, the first L step follows 4 edges later and returns the phase to its prior value.
REQ-035 Scenario: right and left asserted together, or clkdiv=0 with right held -> both held: phase frozen and moving=0; clkdiv=0: one step per edge.
REQ-036 Scenario: reset pulsed between CLK edges during acceleration at level 2 -> all outputs are 0 immediately; after release the first step occurs clkdiv edges later at level 0.
REQ-037 Scenario: CHANNELS=4, all channels driven with different directions at the same time -> each channel matches a single-channel reference model, with no cross-channel interaction.

Source files
------------

// File: rtl/steer_quad_multi.sv
// Multi-channel quadrature steering generator.
// Each channel turns a right/left request into a 2-bit Gray-coded phase
// that advances once per step period, with an optional acceleration ramp
// that halves the period every ACCEL_STEPS steps up to MAX_LVL.
module steer_quad_multi #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned ACCEL_STEPS = 4,
  parameter int unsigned MAX_LVL     = 3
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [DIV_W-1:0]    clkdiv,
  input  logic                accel_en,
  input  logic [CHANNELS-1:0] right,
  input  logic [CHANNELS-1:0] left,
  output logic [CHANNELS-1:0] steer_a,
  output logic [CHANNELS-1:0] steer_b,
  output logic [CHANNELS-1:0] moving
);

  typedef enum logic [1:0] {DirIdle, DirR, DirL} dir_e;

  localparam logic [2:0] LvlMax   = 3'(MAX_LVL);
  localparam logic [7:0] StepsMax = 8'(ACCEL_STEPS);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    dir_e             dir;
    dir_e             dir_q;
    logic [1:0]       p_q, p_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       lvl_q, lvl_d;
    logic [7:0]       sc_q, sc_d;
    logic             a_q, b_q;
    logic [2:0]       lvl_eff;
    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] period_m1;

    // Decode the request pair and derive the current step period.
    always_comb begin
      dir = DirIdle;
      if (right[g] && !left[g]) dir = DirR;
      else if (left[g] && !right[g]) dir = DirL;
      // Dropping accel_en takes effect on this very edge, keeping cnt.
      lvl_eff   = accel_en ? lvl_q : 3'd0;
      period    = clkdiv >> lvl_eff;
      period_m1 = (period == '0) ? '0 : period - 1'b1;
    end

    // Next-state: reset the ramp on idle or reversal, otherwise count and step.
    always_comb begin
      p_d   = p_q;
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      sc_d  = sc_q;
      if (dir == DirIdle || dir != dir_q) begin
        cnt_d = '0;
        lvl_d = '0;
        sc_d  = '0;
      end else begin
        lvl_d = lvl_eff;
        // >= rather than == so a shrinking period never lets cnt wrap.
        if (cnt_q >= period_m1) begin
          p_d   = (dir == DirR) ? p_q + 2'd1 : p_q - 2'd1;
          cnt_d = '0;
          if (accel_en && sc_q >= StepsMax - 8'd1 && lvl_eff < LvlMax) begin
            lvl_d = lvl_eff + 3'd1;
            sc_d  = '0;
          end else if (sc_q < StepsMax) begin
            sc_d = sc_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Channel state and registered outputs.
    always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
        dir_q <= DirIdle;
        p_q   <= '0;
        cnt_q <= '0;
        lvl_q <= '0;
        sc_q  <= '0;
        a_q   <= 1'b0;
        b_q   <= 1'b0;
      end else begin
        dir_q <= dir;
        p_q   <= p_d;
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
        sc_q  <= sc_d;
        // p = 0,1,2,3 maps to AB = 00,01,11,10.
        a_q   <= p_d[1];
        b_q   <= p_d[1] ^ p_d[0];
      end
    end

    assign steer_a[g] = a_q;
    assign steer_b[g] = b_q;
    assign moving[g]  = (dir_q != DirIdle);
  end

endmodule

// File: tb/tb_steer_quad_multi.sv
// Directed bench for steer_quad_multi with hand-computed expectations.
module tb_steer_quad_multi;

  localparam int unsigned CH = 4;

  logic          CLK = 1'b0;
  logic          reset;
  logic [15:0]   clkdiv;
  logic          accel_en;
  logic [CH-1:0] right;
  logic [CH-1:0] left;
  logic [CH-1:0] steer_a;
  logic [CH-1:0] steer_b;
  logic [CH-1:0] moving;

  int n_checks = 0;
  int n_errors = 0;

  steer_quad_multi #(
    .CHANNELS    (CH),
    .DIV_W       (16),
    .ACCEL_STEPS (2),
    .MAX_LVL     (3)
  ) dut (
    .CLK      (CLK),
    .reset    (reset),
    .clkdiv   (clkdiv),
    .accel_en (accel_en),
    .right    (right),
    .left     (left),
    .steer_a  (steer_a),
    .steer_b  (steer_b),
    .moving   (moving)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic logic [1:0] ab0();
    return {steer_a[0], steer_b[0]};
  endfunction

  // Synchronous-style reset pulse leaving the bench just after an edge.
  task automatic do_reset();
    right = '0;
    left  = '0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    clkdiv   = 16'd4;
    accel_en = 1'b0;
    right    = '0;
    left     = '0;
    #1;
    check("reset_a", 32'(steer_a), 32'h0);
    check("reset_b", 32'(steer_b), 32'h0);
    check("reset_mv", 32'(moving), 32'h0);
    tick(2);
    reset = 1'b0;

    // Right on channel 0, period 4, no ramp.
    right = 4'b0001;
    tick();                                   // edge 0
    check("r_mv_e0", 32'(moving), 32'h1);
    check("r_ab_e0", 32'(ab0()), 32'h0);
    tick(3);                                  // edge 3
    check("r_ab_e3", 32'(ab0()), 32'h0);
    tick();                                   // edge 4
    check("r_ab_e4", 32'(ab0()), 32'h1);
    check("r_ch1_e4", 32'({steer_a[1], steer_b[1], moving[1]}), 32'h0);
    tick(4);
    check("r_ab_e8", 32'(ab0()), 32'h3);
    tick(4);
    check("r_ab_e12", 32'(ab0()), 32'h2);
    tick(4);
    check("r_ab_e16", 32'(ab0()), 32'h0);
    right = '0;
    tick();
    check("r_idle_mv", 32'(moving), 32'h0);

    // Reversal: right for edges 0..5, left from edge 6.
    do_reset();
    right = 4'b0001;
    tick(5);                                  // edge 4
    check("rev_ab_e4", 32'(ab0()), 32'h1);
    tick();                                   // edge 5
    right = '0;
    left  = 4'b0001;
    tick();                                   // edge 6: reversal, no step
    check("rev_ab_e6", 32'(ab0()), 32'h1);
    check("rev_mv_e6", 32'(moving[0]), 32'h1);
    tick(3);                                  // edge 9
    check("rev_ab_e9", 32'(ab0()), 32'h1);
    tick();                                   // edge 10
    check("rev_ab_e10", 32'(ab0()), 32'h0);

    // Acceleration ramp: clkdiv 8, steps at 8,16,20,24,26,28,29,30,31.
    do_reset();
    clkdiv   = 16'd8;
    accel_en = 1'b1;
    left     = 4'b0001;
    tick(8);                                  // edge 7
    check("acc_e7", 32'(ab0()), 32'h0);
    tick();
    check("acc_e8", 32'(ab0()), 32'h2);
    tick(7);
    check("acc_e15", 32'(ab0()), 32'h2);
    tick();
    check("acc_e16", 32'(ab0()), 32'h3);
    tick(3);
    check("acc_e19", 32'(ab0()), 32'h3);
    tick();
    check("acc_e20", 32'(ab0()), 32'h1);
    tick(4);
    check("acc_e24", 32'(ab0()), 32'h0);
    tick();
    check("acc_e25", 32'(ab0()), 32'h0);
    tick();
    check("acc_e26", 32'(ab0()), 32'h2);
    tick(2);
    check("acc_e28", 32'(ab0()), 32'h3);
    tick();
    check("acc_e29", 32'(ab0()), 32'h1);
    tick();
    check("acc_e30", 32'(ab0()), 32'h0);
    tick();
    check("acc_e31", 32'(ab0()), 32'h2);
    // Ramp dropped: period back to 8 at once, cnt restarts from 0 after the last step.
    accel_en = 1'b0;
    tick(7);                                  // edge 38
    check("acc_off_e38", 32'(ab0()), 32'h2);
    tick();                                   // edge 39
    check("acc_off_e39", 32'(ab0()), 32'h3);

    // Both requests: frozen and not moving.
    do_reset();
    clkdiv = 16'd4;
    right  = 4'b0001;
    left   = 4'b0001;
    tick(6);
    check("both_ab", 32'(ab0()), 32'h0);
    check("both_mv", 32'(moving), 32'h0);
    // clkdiv 0: one step per edge.
    do_reset();
    clkdiv = 16'd0;
    right  = 4'b0001;
    tick();
    check("div0_e0", 32'(ab0()), 32'h0);
    tick();
    check("div0_e1", 32'(ab0()), 32'h1);
    tick();
    check("div0_e2", 32'(ab0()), 32'h3);
    tick();
    check("div0_e3", 32'(ab0()), 32'h2);

    // Async reset during the ramp at level 2, then restart at level 0.
    do_reset();
    clkdiv   = 16'd8;
    accel_en = 1'b1;
    left     = 4'b0001;
    tick(28);                                 // edge 27
    check("rst_pre_ab", 32'(ab0()), 32'h2);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_a", 32'(steer_a), 32'h0);
    check("rst_async_b", 32'(steer_b), 32'h0);
    check("rst_async_mv", 32'(moving), 32'h0);
    tick();
    reset = 1'b0;
    tick();                                   // edge 0 after release
    check("rst_rel_mv", 32'(moving), 32'h1);
    tick(7);                                  // edge 7
    check("rst_rel_e7", 32'(ab0()), 32'h0);
    tick();                                   // edge 8
    check("rst_rel_e8", 32'(ab0()), 32'h2);

    // Four channels at once: R, L, both, none; period 2.
    do_reset();
    clkdiv   = 16'd2;
    accel_en = 1'b0;
    right    = 4'b0101;
    left     = 4'b0110;
    tick();
    check("mc_mv", 32'(moving), 32'h3);
    tick(2);                                  // edge 2
    check("mc_a_e2", 32'(steer_a), 32'h2);
    check("mc_b_e2", 32'(steer_b), 32'h1);
    tick(2);                                  // edge 4
    check("mc_a_e4", 32'(steer_a), 32'h3);
    check("mc_b_e4", 32'(steer_b), 32'h3);
    tick(2);                                  // edge 6
    check("mc_a_e6", 32'(steer_a), 32'h1);
    check("mc_b_e6", 32'(steer_b), 32'h2);
    check("mc_mv_e6", 32'(moving), 32'h3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
